// File: rtl/card_uart_pkg.sv
// Shared state type, frame bit indices and bit/parity helpers for the card-side UART.
package card_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_BITS,
        RX_ERRSIG,
        RX_GUARD,
        TX_BITS,
        TX_CHECK,
        TX_GUARD
    } uartState_t;

    localparam logic [3:0] START_IDX  = 4'd0;
    localparam logic [3:0] PARITY_IDX = 4'd9;
    localparam logic [3:0] STOP_IDX   = 4'd10;
    localparam logic [3:0] GUARD_ETU  = 4'd12;

    // Parity bit that makes data+parity hold an odd (oddParity=1) or even count of ones.
    function automatic logic parityBit(input logic [7:0] data, input logic oddParity);
        return (^data) ^ oddParity;
    endfunction

    function automatic logic [7:0] bitReverse(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[7-i];
        end
        return r;
    endfunction

    // Line level of frame bit idx: start, data in the selected order, parity, then idle.
    function automatic logic charBit(input logic [7:0] data, input logic [3:0] idx,
                                     input logic msbFirst, input logic oddParity,
                                     input logic startBit);
        logic [3:0] pos;
        logic       bitVal;
        pos = msbFirst ? (4'd8 - idx) : (idx - 4'd1);
        if (idx == START_IDX) begin
            bitVal = startBit;
        end else if (idx == PARITY_IDX) begin
            bitVal = parityBit(data, oddParity);
        end else if (idx < PARITY_IDX) begin
            bitVal = data[pos[2:0]];
        end else begin
            bitVal = ~startBit;
        end
        return bitVal;
    endfunction

endpackage

// File: rtl/card_etu_timer.sv
// ETU timer shared by receive and transmit: cycle-within-ETU counter, ETU index and
// the half-bit / end-of-ETU strobes derived from them.
module card_etu_timer #(
    parameter int CLOCK_PER_BIT_WIDTH = 13
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           run,
    input  logic                           start,
    input  logic                           skipFirst,
    input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
    output logic [3:0]                     bitIdx,
    output logic                           halfStrobe,
    output logic                           preHalfStrobe,
    output logic                           etuEnd
);

    logic [CLOCK_PER_BIT_WIDTH-1:0] etuCnt;
    logic [CLOCK_PER_BIT_WIDTH-1:0] halfPoint;

    assign halfPoint     = clocksPerBit >> 1;
    assign halfStrobe    = (etuCnt == halfPoint);
    assign preHalfStrobe = (etuCnt == halfPoint - CLOCK_PER_BIT_WIDTH'(1));
    assign etuEnd        = (etuCnt == clocksPerBit - CLOCK_PER_BIT_WIDTH'(1));

    // skipFirst makes the start cycle itself count as t=0 of the character.
    always_ff @(posedge clk) begin
        if (reset) begin
            etuCnt <= '0;
            bitIdx <= '0;
        end else if (start) begin
            etuCnt <= CLOCK_PER_BIT_WIDTH'(skipFirst);
            bitIdx <= '0;
        end else if (!run) begin
            etuCnt <= '0;
            bitIdx <= '0;
        end else if (etuEnd) begin
            etuCnt <= '0;
            bitIdx <= bitIdx + 4'd1;
        end else begin
            etuCnt <= etuCnt + CLOCK_PER_BIT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/card_half_duplex_uart.sv
// Card-side half-duplex ISO7816-3 character UART. Define CARD_ERROR_SIGNAL_EN to add
// T=0 error signalling on received parity errors and retransmission on reader errors.
module card_half_duplex_uart
    import card_uart_pkg::*;
#(
    parameter int   CLOCK_PER_BIT_WIDTH = 13,
    parameter int   MAX_RETRY           = 3,
    parameter logic START_BIT           = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           serialIn,
    output logic                           serialOut,
    output logic                           isTx,
    input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
    input  logic [7:0]                     extraGuard,
    input  logic                           oddParity,
    input  logic                           msbFirst,
    input  logic [7:0]                     txData,
    input  logic                           txStart,
    output logic                           txReady,
    output logic                           txDone,
    output logic                           txFail,
    output logic [7:0]                     rxData,
    output logic                           rxValid,
    output logic                           rxParityError
);

    uartState_t state, nextState;
    logic       timerStart, timerSkip, timerRun;
    logic [3:0] bitIdx;
    logic       halfStrobe, preHalfStrobe, etuEnd;
    logic [7:0] txLatch, rxShift;
    logic       rxParBad, txErr, retryLeft, errSigOn;
    logic [8:0] guardEtu;
    logic       guardEnd;

    assign timerRun = (state != IDLE);
    assign guardEnd = (state == TX_GUARD) && etuEnd &&
                      (guardEtu == {1'b0, extraGuard} + 9'(GUARD_ETU - STOP_IDX - 4'd1));

    card_etu_timer #(.CLOCK_PER_BIT_WIDTH(CLOCK_PER_BIT_WIDTH)) etuTimer (
        .clk           (clk),
        .reset         (reset),
        .run           (timerRun),
        .start         (timerStart),
        .skipFirst     (timerSkip),
        .clocksPerBit  (clocksPerBit),
        .bitIdx        (bitIdx),
        .halfStrobe    (halfStrobe),
        .preHalfStrobe (preHalfStrobe),
        .etuEnd        (etuEnd)
    );

`ifdef CARD_ERROR_SIGNAL_EN
    localparam int RETRY_WIDTH = $clog2(MAX_RETRY + 1);
    logic [RETRY_WIDTH-1:0] retryCnt;

    assign errSigOn  = 1'b1;
    assign retryLeft = (retryCnt < RETRY_WIDTH'(MAX_RETRY));

    // A low line at the check point after our parity bit is the reader's error signal.
    always_ff @(posedge clk) begin
        if (reset) begin
            retryCnt <= '0;
            txErr    <= 1'b0;
        end else begin
            if (state == IDLE && nextState == TX_BITS) begin
                retryCnt <= '0;
            end else if (guardEnd && nextState == TX_BITS) begin
                retryCnt <= retryCnt + RETRY_WIDTH'(1);
            end
            if (state == TX_CHECK && halfStrobe) begin
                txErr <= (serialIn == START_BIT);
            end
        end
    end
`else
    assign errSigOn  = 1'b0;
    assign retryLeft = 1'b0;
    assign txErr     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Receive shift, latched transmit byte and extra-guard ETU count.
    always_ff @(posedge clk) begin
        if (reset) begin
            txLatch  <= '0;
            rxShift  <= '0;
            rxData   <= '0;
            rxParBad <= 1'b0;
            guardEtu <= '0;
        end else begin
            if (state == IDLE && nextState == TX_BITS) begin
                txLatch <= txData;
            end
            if (state == RX_BITS && halfStrobe) begin
                if (bitIdx >= 4'd1 && bitIdx <= 4'd8) begin
                    rxShift <= {serialIn, rxShift[7:1]};
                end
                if (bitIdx == PARITY_IDX) begin
                    rxData   <= msbFirst ? bitReverse(rxShift) : rxShift;
                    rxParBad <= (parityBit(rxShift, oddParity) != serialIn);
                end
            end
            if (state == TX_CHECK) begin
                guardEtu <= '0;
            end else if (state == TX_GUARD && etuEnd) begin
                guardEtu <= guardEtu + 9'd1;
            end
        end
    end

    always_comb begin
        nextState  = state;
        timerStart = 1'b0;
        timerSkip  = 1'b0;
        case (state)
            IDLE: begin
                if (serialIn == START_BIT) begin
                    nextState  = RX_BITS;
                    timerStart = 1'b1;
                    timerSkip  = 1'b1;
                end else if (txStart) begin
                    nextState  = TX_BITS;
                    timerStart = 1'b1;
                end
            end
            RX_BITS: begin
                if (halfStrobe && bitIdx == START_IDX && serialIn != START_BIT) begin
                    nextState = IDLE;
                end else if (halfStrobe && bitIdx == STOP_IDX) begin
                    nextState = (errSigOn && rxParBad) ? RX_ERRSIG : RX_GUARD;
                end
            end
            RX_ERRSIG: begin
                if (preHalfStrobe && bitIdx == STOP_IDX + 4'd1) begin
                    nextState = RX_GUARD;
                end
            end
            RX_GUARD: begin
                if (etuEnd && bitIdx == GUARD_ETU - 4'd1) begin
                    nextState = IDLE;
                end
            end
            TX_BITS: begin
                if (etuEnd && bitIdx == PARITY_IDX) begin
                    nextState = TX_CHECK;
                end
            end
            TX_CHECK: begin
                if (halfStrobe) begin
                    nextState = TX_GUARD;
                end
            end
            TX_GUARD: begin
                if (guardEnd) begin
                    if (txErr && retryLeft) begin
                        nextState  = TX_BITS;
                        timerStart = 1'b1;
                    end else begin
                        nextState = IDLE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        serialOut     = ~START_BIT;
        isTx          = 1'b0;
        txReady       = (state == IDLE);
        txDone        = 1'b0;
        txFail        = 1'b0;
        rxValid       = 1'b0;
        rxParityError = 1'b0;
        case (state)
            RX_BITS: begin
                if (halfStrobe && bitIdx == STOP_IDX) begin
                    rxValid       = 1'b1;
                    rxParityError = rxParBad;
                    if (errSigOn && rxParBad) begin
                        isTx      = 1'b1;
                        serialOut = START_BIT;
                    end
                end
            end
            RX_ERRSIG: begin
                isTx      = 1'b1;
                serialOut = START_BIT;
            end
            TX_BITS: begin
                isTx      = 1'b1;
                serialOut = charBit(txLatch, bitIdx, msbFirst, oddParity, START_BIT);
            end
            TX_GUARD: begin
                if (guardEnd) begin
                    txDone = !txErr;
                    txFail = txErr && !retryLeft;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_card_half_duplex_uart.sv
// Self-checking bench for card_half_duplex_uart; follows CARD_ERROR_SIGNAL_EN when defined.
module tb_card_half_duplex_uart;

    localparam int W    = 13;
    localparam int MAXR = 3;
`ifdef CARD_ERROR_SIGNAL_EN
    localparam bit ERRSIG = 1'b1;
`else
    localparam bit ERRSIG = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, serialIn, serialOut, isTx, txReady, txDone, txFail;
    logic         rxValid, rxParityError, oddParity, msbFirst, txStart;
    logic [W-1:0] clocksPerBit;
    logic [7:0]   extraGuard, txData, rxData;
    int           assertCount = 0;
    int           failCount   = 0;

    always #5 clk = ~clk;

    card_half_duplex_uart dut (
        .clk           (clk),
        .reset         (reset),
        .serialIn      (serialIn),
        .serialOut     (serialOut),
        .isTx          (isTx),
        .clocksPerBit  (clocksPerBit),
        .extraGuard    (extraGuard),
        .oddParity     (oddParity),
        .msbFirst      (msbFirst),
        .txData        (txData),
        .txStart       (txStart),
        .txReady       (txReady),
        .txDone        (txDone),
        .txFail        (txFail),
        .rxData        (rxData),
        .rxValid       (rxValid),
        .rxParityError (rxParityError)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference character frame: index 0 start, 1..8 data in line order, 9 parity.
    function automatic logic [9:0] frameBits(input logic [7:0] d, input bit odd, input bit msb);
        logic [9:0] f;
        int         ones;
        ones = $countones(d);
        f[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            f[k] = msb ? d[8-k] : d[k-1];
        end
        f[9] = ((ones % 2) == 1) ^ odd;
        return f;
    endfunction

    // Reader sends one character; optional txStart in the same cycle as the start edge.
    task automatic applyStimulus(input string tag, input logic [7:0] d, input bit odd,
                                 input bit msb, input bit flipPar, input bit alsoTx);
        logic [9:0] fr;
        int         cpb, half, vT, vCnt, pulseCnt, lineBad;
        logic [7:0] gotData;
        logic       gotPe, readyEarly, expTx;
        cpb = int'(clocksPerBit);
        half = cpb / 2;
        vT = -1; vCnt = 0; pulseCnt = 0; lineBad = 0;
        gotData = 8'h00; gotPe = 1'b0; readyEarly = 1'b1;
        fr = frameBits(d, odd, msb);
        if (flipPar) fr[9] = ~fr[9];
        oddParity = odd;
        msbFirst  = msb;
        txData    = ~d;
        for (int t = 0; t < 12 * cpb + 4; t++) begin
            serialIn = (t < 10 * cpb) ? fr[t / cpb] : 1'b1;
            txStart  = alsoTx && (t == 0);
            expTx    = ERRSIG && flipPar && (t >= 10 * cpb + half) && (t < 11 * cpb + half);
            if (isTx !== expTx || (expTx && serialOut !== 1'b0)) lineBad++;
            if (rxValid === 1'b1) begin
                vCnt++;
                if (vT < 0) begin
                    vT = t;
                    gotData = rxData;
                    gotPe = rxParityError;
                end
            end
            if (txDone === 1'b1 || txFail === 1'b1) pulseCnt++;
            if (t == 1) readyEarly = txReady;
            tick();
        end
        serialIn = 1'b1;
        txStart  = 1'b0;
        checkOutput({tag, "/rxValidAt"}, vT, 10 * cpb + half);
        checkOutput({tag, "/rxValidCount"}, vCnt, 1);
        checkOutput({tag, "/rxData"}, gotData, d);
        checkOutput({tag, "/rxParityError"}, gotPe, flipPar);
        checkOutput({tag, "/lineDrive"}, lineBad, 0);
        checkOutput({tag, "/txReadyBusy"}, readyEarly, 1'b0);
        checkOutput({tag, "/txPulses"}, pulseCnt, 0);
        checkOutput({tag, "/txReadyAfter"}, txReady, 1'b1);
    endtask

    // Card transmits one character; the reader optionally signals an error on every attempt.
    task automatic runTx(input string tag, input logic [7:0] d, input bit odd, input bit msb,
                         input int eg, input bit pullErr);
        logic [9:0] fr, cap;
        int         cpb, half, period, expAttempts, budget, riseT, firstRise, rel;
        int         attempts, frameBad, widthBad, hiCnt, doneT, failT, doneCnt, failCnt;
        logic       prev;
        cpb = int'(clocksPerBit);
        half = cpb / 2;
        period = (12 + eg) * cpb;
        expAttempts = (ERRSIG && pullErr) ? MAXR + 1 : 1;
        budget = expAttempts * period + 2 * cpb;
        fr = frameBits(d, odd, msb);
        cap = '0;
        riseT = -1; firstRise = -1; attempts = 0; frameBad = 0; widthBad = 0; hiCnt = 0;
        doneT = -1; failT = -1; doneCnt = 0; failCnt = 0; prev = 1'b0;
        checkOutput({tag, "/readyBefore"}, txReady, 1'b1);
        oddParity  = odd;
        msbFirst   = msb;
        extraGuard = 8'(eg);
        txData     = d;
        for (int t = 0; t <= budget; t++) begin
            txStart = (t == 0);
            if (isTx === 1'b1 && prev !== 1'b1) begin
                if (attempts > 0) begin
                    if (cap !== fr) frameBad++;
                    if (hiCnt != 10 * cpb) widthBad++;
                end
                attempts++;
                riseT = t;
                hiCnt = 0;
                cap = '0;
                if (firstRise < 0) firstRise = t;
            end
            if (isTx === 1'b1) hiCnt++;
            rel = t - riseT;
            if (riseT >= 0 && rel < 10 * cpb && (rel % cpb) == half) cap[rel / cpb] = serialOut;
            serialIn = !(pullErr && riseT >= 0 && rel >= 10 * cpb + half - 2 &&
                         rel < 11 * cpb + half - 2);
            if (txDone === 1'b1) begin
                doneCnt++;
                if (doneT < 0) doneT = t;
            end
            if (txFail === 1'b1) begin
                failCnt++;
                if (failT < 0) failT = t;
            end
            prev = isTx;
            tick();
        end
        txStart  = 1'b0;
        serialIn = 1'b1;
        if (attempts > 0) begin
            if (cap !== fr) frameBad++;
            if (hiCnt != 10 * cpb) widthBad++;
        end
        checkOutput({tag, "/firstDrive"}, firstRise, 1);
        checkOutput({tag, "/attempts"}, attempts, expAttempts);
        checkOutput({tag, "/frameBits"}, frameBad, 0);
        checkOutput({tag, "/driveWidth"}, widthBad, 0);
        checkOutput({tag, "/txDoneCount"}, doneCnt, (ERRSIG && pullErr) ? 0 : 1);
        checkOutput({tag, "/txDoneAt"}, doneT, (ERRSIG && pullErr) ? -1 : period);
        checkOutput({tag, "/txFailCount"}, failCnt, (ERRSIG && pullErr) ? 1 : 0);
        checkOutput({tag, "/txFailAt"}, failT, (ERRSIG && pullErr) ? expAttempts * period : -1);
        checkOutput({tag, "/readyAfter"}, txReady, 1'b1);
    endtask

    initial begin
        int   vCnt, pulses, ready1, readyEtu, stray;
        logic [7:0] rd;

        reset        = 1'b1;
        serialIn     = 1'b1;
        txStart      = 1'b0;
        clocksPerBit = W'(16);
        extraGuard   = 8'd0;
        oddParity    = 1'b0;
        msbFirst     = 1'b0;
        txData       = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        $display("[TB] reset state");
        checkOutput("reset/serialOut", serialOut, 1'b1);
        checkOutput("reset/isTx", isTx, 1'b0);
        checkOutput("reset/txReady", txReady, 1'b1);
        checkOutput("reset/txDone", txDone, 1'b0);
        checkOutput("reset/txFail", txFail, 1'b0);
        checkOutput("reset/rxValid", rxValid, 1'b0);
        checkOutput("reset/rxParityError", rxParityError, 1'b0);
        checkOutput("reset/rxData", rxData, 8'h00);

        $display("[TB] directed receive");
        applyStimulus("rx3B", 8'h3B, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) tick();
        applyStimulus("rx3Bbad", 8'h3B, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) tick();

        $display("[TB] directed transmit");
        runTx("txA5", 8'hA5, 1'b1, 1'b1, 0, 1'b0);
        repeat (5) tick();
        runTx("txA5g2", 8'hA5, 1'b1, 1'b1, 2, 1'b0);
        repeat (5) tick();
        runTx("txRetry", 8'h5C, 1'b0, 1'b0, 0, 1'b1);
        repeat (5) tick();

        $display("[TB] idle glitch");
        vCnt = 0; ready1 = -1; readyEtu = -1;
        for (int t = 0; t < 12 * 16; t++) begin
            serialIn = (t < 8) ? 1'b0 : 1'b1;
            if (rxValid === 1'b1) vCnt++;
            if (t == 1) ready1 = int'(txReady);
            if (t == 16) readyEtu = int'(txReady);
            tick();
        end
        checkOutput("glitch/rxValid", vCnt, 0);
        checkOutput("glitch/readyBusy", ready1, 0);
        checkOutput("glitch/readyWithinEtu", readyEtu, 1);

        $display("[TB] start edge and txStart together");
        applyStimulus("rxWins", 8'hC6, 1'b1, 1'b0, 1'b0, 1'b1);
        stray = 0;
        for (int t = 0; t < 40; t++) begin
            if (isTx !== 1'b0 || txDone !== 1'b0) stray++;
            tick();
        end
        checkOutput("rxWins/noTx", stray, 0);

        $display("[TB] reset during transmission");
        txData  = 8'h96;
        txStart = 1'b1;
        tick();
        txStart = 1'b0;
        for (int t = 0; t < 5 * 16 + 2; t++) tick();
        checkOutput("midReset/busyBefore", isTx, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midReset/isTx", isTx, 1'b0);
        checkOutput("midReset/txReady", txReady, 1'b1);
        pulses = 0;
        for (int t = 0; t < 300; t++) begin
            if (txDone !== 1'b0 || txFail !== 1'b0 || isTx !== 1'b0) pulses++;
            tick();
        end
        checkOutput("midReset/quiet", pulses, 0);

        $display("[TB] randomized characters");
        for (int i = 0; i < 4; i++) begin
            clocksPerBit = W'($urandom_range(24, 6));
            rd = 8'($urandom);
            applyStimulus("rxRand", rd, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            repeat (3) tick();
            rd = 8'($urandom);
            runTx("txRand", rd, 1'($urandom), 1'($urandom), int'($urandom_range(2, 0)),
                  1'($urandom));
            repeat (3) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
